// File: rtl/soc_system_led_pio_pkg.sv
// soc_system_led_pio_pkg: register addresses and widths shared by the LED PIO
package soc_system_led_pio_pkg;
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_SET    = 3'd4;
   localparam logic [2:0] ADDR_CLR    = 3'd5;
   localparam logic [2:0] ADDR_PWM    = 3'd6;
   localparam int PWM_W = 8;
   localparam int STATUS_PHASE_BIT = 0;
endpackage

// File: rtl/soc_system_led_blink_pio_if.sv
// soc_system_led_blink_pio_if: Avalon-MM slave bus of the LED PIO
interface soc_system_led_blink_pio_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_led_pio_blink_timer.sv
// soc_system_led_pio_blink_timer: prescaler, period counter and blink phase
module soc_system_led_pio_blink_timer #(
   parameter int PRESCALE = 50000,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] period,
   input  logic                restart,
   output logic                phase
);
   localparam int PRE_W = $clog2(PRESCALE);
   logic [PRE_W-1:0]    pre;
   logic [PERIOD_W-1:0] cnt;
   logic                tick;
   assign tick = pre == PRE_W'(PRESCALE - 1);
   // restart or a zero period parks everything at 0; otherwise phase flips every period ticks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n || restart || period == '0) begin
         pre   <= '0;
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) begin
            cnt   <= (cnt == period - 1'b1) ? '0 : cnt + 1'b1;
            phase <= (cnt == period - 1'b1) ? ~phase : phase;
         end
      end
   end
endmodule

// File: rtl/soc_system_led_blink_pio.sv
// soc_system_led_blink_pio: Avalon-MM LED PIO with set/clear, hardware blink; SOC_LED_PIO_PWM_EN adds PWM dimming
module soc_system_led_blink_pio
   import soc_system_led_pio_pkg::*;
#(
   parameter int               WIDTH       = 7,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               PRESCALE    = 50000,
   parameter int               PERIOD_W    = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   soc_system_led_blink_pio_if.slave   bus,
   output logic [WIDTH-1:0]            out_port
);
   logic                wr, phase, pwm_on, unused_wd;
   logic [2:0]          addr;
   logic [WIDTH-1:0]    data, mask, wd;
   logic [PERIOD_W-1:0] period;
   logic [31:0]         pwm_rd;
   assign wr        = bus.chipselect & ~bus.write_n;
   assign addr      = bus.address;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign unused_wd = ^bus.writedata;
   // register file; set/clear are read-modify-write on DATA
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data   <= RESET_VALUE;
         mask   <= '0;
         period <= '0;
      end else if (wr) begin
         data   <= addr == ADDR_DATA ? wd : addr == ADDR_SET ? data | wd : addr == ADDR_CLR ? data & ~wd : data;
         mask   <= addr == ADDR_MASK ? wd : mask;
         period <= addr == ADDR_PERIOD ? bus.writedata[PERIOD_W-1:0] : period;
      end
   end
   soc_system_led_pio_blink_timer #(.PRESCALE(PRESCALE), .PERIOD_W(PERIOD_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .period  (period),
      .restart (wr && addr == ADDR_PERIOD),
      .phase   (phase)
   );
`ifdef SOC_LED_PIO_PWM_EN
   logic [PWM_W-1:0] pwm_cnt, duty;
   // free-running PWM counter and duty register; counter never restarts on a duty write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
         duty    <= '1;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (wr && addr == ADDR_PWM) duty <= bus.writedata[PWM_W-1:0];
      end
   end
   assign pwm_on = (&duty) | (pwm_cnt < duty);
   assign pwm_rd = 32'(duty);
`else
   assign pwm_on = 1'b1;
   assign pwm_rd = '0;
`endif
   assign out_port = data & ~(mask & {WIDTH{phase}}) & {WIDTH{pwm_on}};
   // read mux, combinational from address, zero-extended
   always_comb begin
      bus.readdata = addr == ADDR_DATA   ? 32'(data) :
                     addr == ADDR_MASK   ? 32'(mask) :
                     addr == ADDR_PERIOD ? 32'(period) :
                     addr == ADDR_STATUS ? 32'(phase) << STATUS_PHASE_BIT :
                     addr == ADDR_PWM    ? pwm_rd : '0;
   end
endmodule

// File: tb/tb_soc_system_led_blink_pio.sv
// tb_soc_system_led_blink_pio: randomized self-checking bench against a timeline-based model
module tb_soc_system_led_blink_pio;
   localparam int WIDTH = 7;
   localparam logic [6:0] RV = 7'h55;
   localparam int PRESCALE = 4;
   localparam int PERIOD_W = 8;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic [6:0] out_port;
   int total = 0, bad = 0;
   soc_system_led_blink_pio_if bus ();
   soc_system_led_blink_pio #(.WIDTH(WIDTH), .RESET_VALUE(RV), .PRESCALE(PRESCALE), .PERIOD_W(PERIOD_W)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port));
   always #5 clk = ~clk;

   // model state: registers plus elapsed cycles since last blink restart / since reset
   logic [6:0] m_data, m_mask;
   logic [7:0] m_period, m_duty;
   int t, pc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic m_phase();
      if (m_period == 0) return 1'b0;
      return ((t / (PRESCALE * int'(m_period))) % 2) == 1;
   endfunction

   function automatic logic [6:0] m_out();
      logic pwm = 1'b1;
`ifdef SOC_LED_PIO_PWM_EN
      pwm = (m_duty == 8'hFF) || (pc < int'(m_duty));
`endif
      return m_data & ~(m_mask & {7{m_phase()}}) & {7{pwm}};
   endfunction

   function automatic logic [31:0] m_rd(input logic [2:0] a);
      case (a)
         3'd0: return {25'd0, m_data};
         3'd1: return {25'd0, m_mask};
         3'd2: return {24'd0, m_period};
         3'd3: return {31'd0, m_phase()};
`ifdef SOC_LED_PIO_PWM_EN
         3'd6: return {24'd0, m_duty};
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_data = RV; m_mask = 0; m_period = 0; m_duty = 8'hFF; t = 0; pc = 0;
   endtask

   task automatic m_edge(input logic wr, input logic [2:0] a, input logic [31:0] wd);
      t++;
      pc = (pc + 1) % 256;
      if (wr) begin
         case (a)
            3'd0: m_data = wd[6:0];
            3'd1: m_mask = wd[6:0];
            3'd2: begin m_period = wd[7:0]; t = 0; end
            3'd4: m_data = m_data | wd[6:0];
            3'd5: m_data = m_data & ~wd[6:0];
`ifdef SOC_LED_PIO_PWM_EN
            3'd6: m_duty = wd[7:0];
`endif
            default: ;
         endcase
      end
   endtask

   task automatic cyc(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
      bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
      @(posedge clk);
      m_edge(cs & ~wn, a, wd);
      @(negedge clk);
      chk("out_port", {25'd0, out_port}, {25'd0, m_out()});
      chk($sformatf("rd@%0d", a), bus.readdata, m_rd(a));
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
      cyc(a, 1'b1, 1'b0, wd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      m_reset();
      chk("rst_out_async", {25'd0, out_port}, {25'd0, RV});
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      int hi;
      bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
      #2 do_reset();
      for (int a = 0; a < 8; a++) cyc(3'(a), 1'b0, 1'b1, 32'd0);
      wr_reg(3'd0, 32'hFFFF_FF0F);
      wr_reg(3'd4, 32'h30);
      wr_reg(3'd5, 32'h03);
      cyc(3'd0, 1'b0, 1'b1, 0);
      chk("setclr_data", {25'd0, out_port}, 32'h3C);
      wr_reg(3'd0, 32'h7F);
      wr_reg(3'd1, 32'h01);
      wr_reg(3'd2, 32'h3);
      idle(11);
      chk("pre_toggle", {25'd0, out_port}, 32'h7F);
      idle(1);
      chk("first_toggle", {25'd0, out_port}, 32'h7E);
      idle(30);
      for (int i = 0; i < 100 && !(m_phase() && (t % 4 == 3)); i++) idle(1);
      chk("reach_tick_phase1", {31'd0, m_phase() && (t % 4 == 3)}, 32'd1);
      wr_reg(3'd2, 32'h3);
      chk("restart_phase0", {25'd0, out_port}, 32'h7F);
      idle(11);
      chk("restart_hold", {25'd0, out_port}, 32'h7F);
      idle(1);
      chk("restart_toggle", {25'd0, out_port}, 32'h7E);
      wr_reg(3'd2, 32'h0);
      idle(20);
      chk("period0_out", {25'd0, out_port}, 32'h7F);
      wr_reg(3'd2, 32'h2);
      for (int i = 0; i < 100 && !m_phase(); i++) idle(1);
      chk("reach_phase1", {31'd0, m_phase()}, 32'd1);
      do_reset();
      for (int a = 0; a < 8; a++) cyc(3'(a), 1'b0, 1'b1, 32'd0);
`ifdef SOC_LED_PIO_PWM_EN
      wr_reg(3'd0, 32'h7F);
      wr_reg(3'd6, 32'd64);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         idle(1);
         if (out_port == 7'h7F) hi++;
      end
      chk("pwm64_high", hi, 32'd64);
      wr_reg(3'd6, 32'd0);
      idle(20);
      chk("pwm0", {25'd0, out_port}, 32'd0);
      wr_reg(3'd6, 32'd255);
      idle(20);
      chk("pwm255", {25'd0, out_port}, 32'h7F);
`else
      hi = 0;
      wr_reg(3'd6, 32'h40);
      cyc(3'd6, 1'b0, 1'b1, 0);
      chk("addr6_zero", bus.readdata, 32'd0);
`endif
      for (int i = 0; i < 3000; i++) begin
         logic [2:0] a;
         a = 3'($urandom_range(0, 7));
         cyc(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
             a == 3'd2 ? $urandom_range(0, 4) : $urandom);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
